// File: rtl/uart_mmio_bridge.sv
// Register-port sequencer for a 16550: programs divisor/LCR/FCR/IER after reset,
// then polls LSR and shuttles bytes between CPU-side FIFOs and THR/RBR.
module uart_mmio_bridge #(
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16,
  parameter logic [15:0] DIVISOR   = 16'd27,
  parameter logic [7:0]  LCR_VAL   = 8'h03,
  parameter int          BURST_MAX = 16
) (
  input  logic                        clk,
  input  logic                        Rst,
  input  logic                        tx_valid,
  input  logic [7:0]                  tx_data,
  output logic                        tx_ready,
  output logic                        rx_valid,
  output logic [7:0]                  rx_data,
  input  logic                        rx_ready,
  output logic [$clog2(TX_DEPTH):0]   tx_count,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        init_done,
  output logic [2:0]                  err_sticky,
  input  logic                        err_clr,
  output logic [2:0]                  uart_addr,
  output logic [7:0]                  uart_din,
  output logic                        tx_wen,
  output logic                        rx_ren,
  input  logic [7:0]                  uart_dout
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int BC_W  = $clog2(BURST_MAX) + 1;

  localparam logic [TX_AW:0]   TX_FULL   = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [TX_AW:0]   TX_ONE    = (TX_AW + 1)'(1);
  localparam logic [RX_AW:0]   RX_FULL   = (RX_AW + 1)'(RX_DEPTH);
  localparam logic [BC_W-1:0]  BURST_LIM = BC_W'(BURST_MAX);

  localparam logic [2:0] S_INIT_REQ = 3'd0;
  localparam logic [2:0] S_INIT_CAP = 3'd1;
  localparam logic [2:0] S_POLL_REQ = 3'd2;
  localparam logic [2:0] S_POLL_CAP = 3'd3;
  localparam logic [2:0] S_RX_REQ   = 3'd4;
  localparam logic [2:0] S_RX_CAP   = 3'd5;
  localparam logic [2:0] S_TX_BURST = 3'd6;
  localparam logic [2:0] S_TX_IDLE  = 3'd7;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_DLL  = 3'd0;
  localparam logic [2:0] ADDR_DLM  = 3'd1;
  localparam logic [2:0] ADDR_IER  = 3'd1;
  localparam logic [2:0] ADDR_FCR  = 3'd2;
  localparam logic [2:0] ADDR_LCR  = 3'd3;
  localparam logic [2:0] ADDR_LSR  = 3'd5;
  localparam logic [2:0] LAST_STEP = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic             started_q, started_d;
  logic             init_done_q, init_done_d;
  logic [2:0]       err_q, err_d;
  logic [BC_W-1:0]  burst_q, burst_d, burst_inc;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;

  logic             tx_push, tx_pop, rx_push, rx_pop, rx_full;
  logic [2:0]       init_addr, bus_addr;
  logic [7:0]       init_din, bus_din;
  logic             bus_wen, bus_ren;

  // started_q keeps the bus quiet (and tx_ready low) for the cycle after reset.
  assign started_d = 1'b1;
  assign tx_ready  = started_q & (tx_cnt_q != TX_FULL);
  assign tx_push   = tx_valid & tx_ready;
  assign rx_valid  = (rx_cnt_q != '0);
  assign rx_pop    = rx_valid & rx_ready;
  assign rx_full   = (rx_cnt_q == RX_FULL);
  assign rx_data   = rx_valid ? rx_mem[rx_rd_q] : 8'h00;
  assign burst_inc = burst_q + BC_W'(1);

  assign tx_count   = tx_cnt_q;
  assign rx_count   = rx_cnt_q;
  assign init_done  = init_done_q;
  assign err_sticky = err_q;
  assign uart_addr  = bus_addr;
  assign uart_din   = bus_din;
  assign tx_wen     = bus_wen;
  assign rx_ren     = bus_ren;

  always_comb begin
    init_addr = ADDR_LCR;
    init_din  = 8'h00;
    case (step_q)
      3'd0:    begin init_addr = ADDR_LCR; init_din = 8'h80;         end
      3'd1:    begin init_addr = ADDR_DLL; init_din = DIVISOR[7:0];  end
      3'd2:    begin init_addr = ADDR_DLM; init_din = DIVISOR[15:8]; end
      3'd3:    begin init_addr = ADDR_LCR; init_din = LCR_VAL;       end
      3'd4:    begin init_addr = ADDR_FCR; init_din = 8'h07;         end
      3'd5:    begin init_addr = ADDR_IER; init_din = 8'h00;         end
      default: begin init_addr = ADDR_LCR; init_din = 8'h00;         end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    init_done_d = init_done_q;
    burst_d     = burst_q;
    err_d       = err_q;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    bus_addr    = 3'd0;
    bus_din     = 8'h00;
    bus_wen     = 1'b0;
    bus_ren     = 1'b0;
    if (started_q) begin
      case (state_q)
        S_INIT_REQ: begin
          bus_addr = init_addr;
          bus_din  = init_din;
          bus_wen  = 1'b1;
          state_d  = S_INIT_CAP;
          if (step_q == LAST_STEP) init_done_d = 1'b1;
        end
        S_INIT_CAP: begin
          bus_addr = init_addr;
          if (step_q == LAST_STEP) begin
            state_d = S_POLL_REQ;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = S_INIT_REQ;
          end
        end
        S_POLL_REQ: begin
          bus_addr = ADDR_LSR;
          bus_ren  = 1'b1;
          state_d  = S_POLL_CAP;
        end
        S_POLL_CAP: begin
          bus_addr = ADDR_LSR;
          err_d    = err_q | uart_dout[3:1];
          // Receive wins over transmit so the 16550 RX FIFO never overruns first.
          if (uart_dout[0] && !rx_full) begin
            state_d = S_RX_REQ;
          end else if (uart_dout[5] && (tx_cnt_q != '0)) begin
            state_d = S_TX_BURST;
            burst_d = '0;
          end else begin
            state_d = S_POLL_REQ;
          end
        end
        S_RX_REQ: begin
          bus_addr = ADDR_DATA;
          bus_ren  = 1'b1;
          state_d  = S_RX_CAP;
        end
        S_RX_CAP: begin
          bus_addr = ADDR_DATA;
          rx_push  = 1'b1;
          state_d  = S_POLL_REQ;
        end
        S_TX_BURST: begin
          bus_addr = ADDR_DATA;
          bus_din  = tx_mem[tx_rd_q];
          bus_wen  = 1'b1;
          tx_pop   = 1'b1;
          burst_d  = burst_inc;
          // FIFO is non-empty after this pop if more than one entry remains or a push lands now.
          if ((burst_inc < BURST_LIM) && ((tx_cnt_q > TX_ONE) || tx_push)) begin
            state_d = S_TX_BURST;
          end else begin
            state_d = S_TX_IDLE;
          end
        end
        S_TX_IDLE: begin
          state_d = S_POLL_REQ;
        end
        default: begin
          state_d = S_INIT_REQ;
        end
      endcase
    end
    if (err_clr) err_d = 3'b000;
  end

  always_comb begin
    tx_wr_d  = tx_push ? tx_wr_q + TX_AW'(1) : tx_wr_q;
    tx_rd_d  = tx_pop  ? tx_rd_q + TX_AW'(1) : tx_rd_q;
    tx_cnt_d = tx_cnt_q + {{TX_AW{1'b0}}, tx_push} - {{TX_AW{1'b0}}, tx_pop};
    rx_wr_d  = rx_push ? rx_wr_q + RX_AW'(1) : rx_wr_q;
    rx_rd_d  = rx_pop  ? rx_rd_q + RX_AW'(1) : rx_rd_q;
    rx_cnt_d = rx_cnt_q + {{RX_AW{1'b0}}, rx_push} - {{RX_AW{1'b0}}, rx_pop};
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= uart_dout;
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q     <= S_INIT_REQ;
      step_q      <= 3'd0;
      started_q   <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 3'b000;
      burst_q     <= '0;
      tx_wr_q     <= '0;
      tx_rd_q     <= '0;
      tx_cnt_q    <= '0;
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      rx_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      started_q   <= started_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      burst_q     <= burst_d;
      tx_wr_q     <= tx_wr_d;
      tx_rd_q     <= tx_rd_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_wr_q     <= rx_wr_d;
      rx_rd_q     <= rx_rd_d;
      rx_cnt_q    <= rx_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge with a behavioural 16550 register model.
`timescale 1ns/1ps
module tb_uart_mmio_bridge;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       Rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready = 1'b0;
  logic [4:0] tx_count;
  logic [4:0] rx_count;
  logic       init_done;
  logic [2:0] err_sticky;
  logic       err_clr = 1'b0;
  logic [2:0] uart_addr;
  logic [7:0] uart_din;
  logic       tx_wen;
  logic       rx_ren;
  logic [7:0] uart_dout;

  // 16550 model: LSR[0] is set while the bench still has bytes to offer.
  logic [7:0] lsr_base = 8'h00;
  logic [7:0] rbr_val  = 8'h00;
  int         rbr_reads = 0;
  int         rbr_avail = 0;
  logic [7:0] lsr_val;
  assign lsr_val   = lsr_base | {7'b0, (rbr_reads < rbr_avail)};
  assign uart_dout = (uart_addr == 3'd5) ? lsr_val : rbr_val;

  uart_mmio_bridge #(
    .TX_DEPTH(16), .RX_DEPTH(16), .DIVISOR(16'd27), .LCR_VAL(8'h03), .BURST_MAX(16)
  ) dut (
    .clk(clk), .Rst(Rst),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count),
    .init_done(init_done), .err_sticky(err_sticky), .err_clr(err_clr),
    .uart_addr(uart_addr), .uart_din(uart_din), .tx_wen(tx_wen), .rx_ren(rx_ren),
    .uart_dout(uart_dout)
  );

  typedef struct { int cyc; logic [2:0] addr; logic [7:0] din; } acc_t;
  acc_t wr_q[$];
  acc_t rd_q[$];
  int   cyc = 0;
  int   done_rise_cyc = -1;
  int   init_reads = 0;
  int   excl_bad = 0;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (tx_wen) wr_q.push_back('{cyc, uart_addr, uart_din});
    if (rx_ren) begin
      rd_q.push_back('{cyc, uart_addr, 8'h00});
      if (uart_addr == 3'd0) rbr_reads++;
      if (!init_done) init_reads++;
    end
    if (tx_wen && rx_ren) excl_bad++;
    if (init_done && !done_prev) done_rise_cyc = cyc;
    done_prev = init_done;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    tick();
    while (!tx_ready && n < 200) begin
      tick();
      n++;
    end
    check_eq("push_ready", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_init();
    for (int n = 0; n < 100 && !init_done; n++) tick();
    check_eq("init_done_seen", init_done, 1);
  endtask

  function automatic int first_rd_after(input int c);
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i].cyc > c) return i;
    return -1;
  endfunction

  function automatic logic [36:0] all_outs();
    return {tx_ready, rx_valid, rx_data, tx_count, rx_count, init_done,
            err_sticky, uart_addr, uart_din, tx_wen, rx_ren};
  endfunction

  logic [2:0] exp_a [6] = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1};
  logic [7:0] exp_d [6] = '{8'h80, 8'h1B, 8'h00, 8'h03, 8'h07, 8'h00};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m, wm, rm, k, run1, run2, rcyc, base;

    // 1: reset state and the six programming writes
    repeat (3) tick();
    check_eq("reset_outs", all_outs(), 0);
    m = wr_q.size();
    Rst = 1'b0;
    wait_init();
    check_eq("init_wr_count", wr_q.size() - m, 6);
    for (int i = 0; i < 6 && m + i < wr_q.size(); i++) begin
      check_eq($sformatf("init_addr%0d", i), wr_q[m+i].addr, exp_a[i]);
      check_eq($sformatf("init_din%0d", i), wr_q[m+i].din, exp_d[i]);
    end
    if (wr_q.size() >= m + 6) check_eq("init_done_cyc", done_rise_cyc, wr_q[m+5].cyc + 1);
    check_eq("init_no_reads", init_reads, 0);

    // 2: short burst of three
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    tick();
    check_eq("t2_cnt3", tx_count, 3);
    m = wr_q.size();
    lsr_base = 8'h60;
    for (int n = 0; n < 100 && wr_q.size() < m + 3; n++) tick();
    repeat (6) tick();
    check_eq("t2_wr_count", wr_q.size() - m, 3);
    for (int i = 0; i < 3 && m + i < wr_q.size(); i++) begin
      check_eq($sformatf("t2_din%0d", i), wr_q[m+i].din, 8'h41 + i);
      check_eq($sformatf("t2_addr%0d", i), wr_q[m+i].addr, 0);
      check_eq($sformatf("t2_cyc%0d", i), wr_q[m+i].cyc - wr_q[m].cyc, i);
    end
    check_eq("t2_cnt0", tx_count, 0);
    if (wr_q.size() >= m + 3) begin
      k = first_rd_after(wr_q[m+2].cyc);
      check_eq("t2_poll_found", k >= 0, 1);
      if (k >= 0) begin
        check_eq("t2_poll_addr", rd_q[k].addr, 5);
        check_eq("t2_poll_cyc", rd_q[k].cyc - wr_q[m+2].cyc, 2);
      end
    end

    // 3: twenty bytes split into 16 + 4
    lsr_base = 8'h00;
    m = wr_q.size();
    for (int i = 0; i < 16; i++) push_byte(8'h10 + i[7:0]);
    tick();
    check_eq("t3_full_cnt", tx_count, 16);
    check_eq("t3_full_rdy", tx_ready, 0);
    lsr_base = 8'h60;
    for (int i = 16; i < 20; i++) push_byte(8'h10 + i[7:0]);
    for (int n = 0; n < 200 && wr_q.size() < m + 20; n++) tick();
    repeat (8) tick();
    check_eq("t3_total", wr_q.size() - m, 20);
    if (wr_q.size() >= m + 20) begin
      for (int i = 0; i < 20; i++) check_eq($sformatf("t3_din%0d", i), wr_q[m+i].din, 8'h10 + i);
      run1 = 1;
      while (run1 < 20 && wr_q[m+run1].cyc == wr_q[m+run1-1].cyc + 1) run1++;
      check_eq("t3_run1", run1, 16);
      check_eq("t3_gap", wr_q[m+16].cyc - wr_q[m+15].cyc, 4);
      run2 = 1;
      while (16 + run2 < 20 && wr_q[m+16+run2].cyc == wr_q[m+15+run2].cyc + 1) run2++;
      check_eq("t3_run2", run2, 4);
      k = first_rd_after(wr_q[m+15].cyc);
      if (k >= 0) check_eq("t3_mid_poll", {rd_q[k].addr, 32'(rd_q[k].cyc - wr_q[m+15].cyc)}, {3'd5, 32'd2});
      else check_eq("t3_mid_poll_found", k, 0);
    end

    // 4: RX wins over TX on the same poll
    lsr_base = 8'h00;
    push_byte(8'h77);
    tick();
    wm = wr_q.size();
    rm = rd_q.size();
    rbr_val   = 8'h5A;
    rbr_avail = rbr_reads + 1;
    lsr_base  = 8'h60;
    for (int n = 0; n < 100 && wr_q.size() <= wm; n++) tick();
    tick();
    check_eq("t4_wr_seen", wr_q.size() > wm, 1);
    rcyc = -1;
    for (int i = rm; i < rd_q.size(); i++)
      if (rcyc < 0 && rd_q[i].addr == 3'd0) rcyc = rd_q[i].cyc;
    if (wr_q.size() > wm) begin
      check_eq("t4_rx_first", (rcyc > 0) && (rcyc < wr_q[wm].cyc), 1);
      check_eq("t4_tx_after", wr_q[wm].cyc - rcyc, 4);
      check_eq("t4_tx_din", wr_q[wm].din, 8'h77);
    end
    check_eq("t4_rx_valid", rx_valid, 1);
    check_eq("t4_rx_data", rx_data, 8'h5A);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check_eq("t4_rx_empty", {rx_valid, rx_count}, 0);

    // 5: RX FIFO full blocks RBR reads
    lsr_base  = 8'h00;
    rbr_val   = 8'h33;
    rbr_avail = rbr_reads + 100000;
    for (int n = 0; n < 300 && rx_count != 16; n++) tick();
    check_eq("t5_full", rx_count, 16);
    base = rbr_reads;
    repeat (20) tick();
    check_eq("t5_no_reads", rbr_reads - base, 0);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    base = rbr_reads;
    repeat (20) tick();
    check_eq("t5_one_read", rbr_reads - base, 1);
    check_eq("t5_refull", rx_count, 16);
    check_eq("t5_data", rx_data, 8'h33);
    rbr_avail = rbr_reads;
    rx_ready = 1'b1;
    for (int n = 0; n < 40 && rx_count != 0; n++) tick();
    rx_ready = 1'b0;
    check_eq("t5_drained", rx_count, 0);

    // 6: sticky errors, clear priority, reset mid-burst
    rbr_val   = 8'hC3;
    rbr_avail = rbr_reads + 1;
    lsr_base  = 8'h0A;
    for (int n = 0; n < 60 && rx_count != 1; n++) tick();
    lsr_base = 8'h00;
    repeat (4) tick();
    check_eq("t6_err", err_sticky, 3'b101);
    check_eq("t6_rx", {rx_count, rx_data}, {5'd1, 8'hC3});
    lsr_base = 8'h04;
    err_clr  = 1'b1;
    repeat (10) tick();
    err_clr  = 1'b0;
    lsr_base = 8'h00;
    check_eq("t6_clr_prio", err_sticky, 3'b000);
    repeat (6) tick();
    check_eq("t6_clr_hold", err_sticky, 3'b000);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;

    for (int i = 0; i < 8; i++) push_byte(8'hA0 + i[7:0]);
    lsr_base = 8'h60;
    for (int n = 0; n < 50 && !tx_wen; n++) tick();
    check_eq("t6_burst_seen", tx_wen, 1);
    tick();
    tick();
    Rst = 1'b1;
    lsr_base = 8'h00;
    tick();
    check_eq("t6_rst_outs", all_outs(), 0);
    tick();
    check_eq("t6_rst_outs2", all_outs(), 0);
    m = wr_q.size();
    Rst = 1'b0;
    wait_init();
    check_eq("t6_reinit_count", wr_q.size() - m, 6);
    if (wr_q.size() > m) check_eq("t6_reinit_first", {wr_q[m].addr, wr_q[m].din}, {3'd3, 8'h80});
    check_eq("t6_burst_lost", tx_count, 0);
    check_eq("init_no_reads2", init_reads, 0);
    check_eq("excl", excl_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_mmio_bridge.md
Name: uart_mmio_bridge

Overview:
- Sequencer that sits directly upstream of the UART controller and drives its MMIO-side register port (uart_addr, uart_din, tx_wen, rx_ren, uart_dout).
- At reset it programs the 16550 divisor, line control and FIFO control registers, then continuously polls LSR.
- It moves bytes between two local FIFOs and the 16550: a CPU-facing TX FIFO drains into THR, and RBR fills a CPU-facing RX FIFO.
- The CPU sees simple valid/ready byte streams and never touches 16550 registers directly.

Parameters:
- TX_DEPTH, 16, TX FIFO entries (power of 2, at least 2).
- RX_DEPTH, 16, RX FIFO entries (power of 2, at least 2).
- DIVISOR, 16'd27, 16550 baud divisor written to DLL/DLM.
- LCR_VAL, 8'h03, final LCR value (8N1, DLAB=0).
- BURST_MAX, 16, maximum THR writes per THRE event (hardware FIFO depth).

Ports:
- clk  in  1  system clock; the single clock of the block.
- Rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  CPU presents a byte to transmit.
- tx_data  in  8  byte to transmit.
- tx_ready  out  1  TX FIFO not full.
- rx_valid  out  1  RX FIFO not empty.
- rx_data  out  8  RX FIFO head (first-word fall-through).
- rx_ready  in  1  CPU pops the head when asserted with rx_valid.
- tx_count  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy.
- rx_count  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
- init_done  out  1  16550 programming complete.
- err_sticky  out  3  sticky {FE,PE,OE} captured from LSR[3:1].
- err_clr  in  1  clears err_sticky.
- uart_addr  out  3  16550 register address.
- uart_din  out  8  16550 write data.
- tx_wen  out  1  16550 write strobe (CS+WR).
- rx_ren  out  1  16550 read strobe (CS, WR=0).
- uart_dout  in  8  16550 read data.

Behaviour:
- Reset (Rst=1 at a clk edge) puts the block in a known state:
  - All outputs are 0 and both FIFOs are emptied.
  - err_sticky = 0.
  - FSM goes to INIT with step = 0.
  - Reset asserted mid-access abandons the access; a pending burst is lost.
- Every access takes two cycles: REQ then CAP.
  - The strobe is high for exactly one cycle (REQ) with addr/din valid.
  - addr is held through CAP, and uart_dout is sampled in CAP.
  - tx_wen and rx_ren are never high together.
- INIT: six writes, one per two-cycle slot (strobe cycle + idle cycle), in this order:
  - LCR=8'h80
  - DLL=DIVISOR[7:0]
  - DLM=DIVISOR[15:8]
  - LCR=LCR_VAL
  - FCR=8'h07
  - IER=8'h00
  - Addresses: LCR=3, DLL/DLM=0/1 while DLAB=1, FCR=2, IER=1.
  - init_done rises in the cycle after the final slot; FSM moves to POLL_REQ.
- POLL_REQ/POLL_CAP: read LSR (addr 5).
  - In CAP: err_sticky |= LSR[3:1].
  - Next state (priority order):
    1. LSR[0]=1 and RX FIFO not full -> RX_REQ.
    2. Else LSR[5]=1 and TX FIFO not empty -> TX_BURST.
    3. Else -> POLL_REQ.
- RX_REQ/RX_CAP: read RBR (addr 0), push uart_dout into the RX FIFO in CAP, then return to POLL_REQ.
- TX_BURST:
  - Each cycle: pop the TX head and write it to THR (addr 0, tx_wen=1).
  - Continue while the burst counter < BURST_MAX and the FIFO is not empty.
  - Then one idle cycle, then POLL_REQ.
  - The burst counter resets on entry.
- FIFO rules:
  - TX push happens when tx_valid&tx_ready.
  - A TX push and a burst pop in the same cycle are both honoured; count is unchanged.
  - tx_ready = tx_count<TX_DEPTH; it is not relaxed by a same-cycle pop.
  - RX pop happens when rx_valid&rx_ready; a push and pop in the same cycle are both honoured.
  - Pointers wrap modulo depth.
  - Counts saturate only logically: overflow/underflow is impossible by construction.
- CPU TX pushes are accepted during INIT; draining starts after init_done.
- err_clr has priority over a same-cycle OR-in: the register becomes 0 that cycle, and the new LSR bits are lost.
- No combinational path from uart_dout to any output.

Test Plan:
1. Reset then run, with DIVISOR=27 -> exactly 6 tx_wen pulses with (addr,din) = (3,80),(0,1B),(1,00),(3,03),(2,07),(1,00); init_done=1 the cycle after the last pulse; rx_ren=0 throughout INIT.
2. Push 0x41,0x42,0x43; model returns LSR=8'h60 -> 3 consecutive tx_wen cycles on addr 0 with din 41,42,43; tx_count goes 3->0; then an LSR poll resumes.
3. Push 20 bytes with LSR THRE always set -> the first burst is exactly 16 writes, followed by a poll, then a 4-write burst; byte order is preserved.
4. Model LSR=8'h61 with RBR=0x5A, and the TX FIFO non-empty -> the RX read is taken first; rx_valid=1 with rx_data=5A; the TX burst follows on the next poll.
5. Fill the RX FIFO to 16 with rx_ready=0 and LSR[0]=1 -> no RBR reads while full; one pop enables exactly one read.
6. LSR=8'h0B once, then err_clr -> err_sticky=3'b101 (FE,OE) and a byte is read; after err_clr, err_sticky=0. Assert Rst mid-burst -> all outputs 0 and INIT restarts from step 0.
